wave_render_mc: RTL and testbench
=================================

// Module: wave_render_mc
// PURPOSE
//   Multi-channel successor to the single-trace oscilloscope RAM reader. Reads CH_NUM sample
//   channels from a shared-address capture RAM in step with the VGA pixel scan and raises one
//   trace bit per channel when the scanned pixel lies on that channel's waveform.
//   Adds a display window, a vertical gain shift, a connected-line draw mode and a
//   frame-aligned freeze handshake. Sits between the capture RAM and the VGA colour mux.
// PARAMETERS
//   CH_NUM   2    number of channels sharing one read address
//   DATA_W   12   sample width per channel (unsigned)
//   ADDR_W   10   RAM address width; window depth = 2**ADDR_W columns
//   X_START  0    first screen column of the window
//   Y_TOP    112  top screen row of the window
//   Y_BASE   368  bottom (zero-level) screen row of the window; Y_BASE > Y_TOP
// PORTS
//   clk           in   1              pixel clock
//   rst_n         in   1              async reset, active low
//   pixel_xpos    in   10             current scan column
//   pixel_ypos    in   10             current scan row
//   ram_rd_en     out  1              RAM read enable
//   ram_rd_addr   out  ADDR_W         RAM read address
//   ram_rd_data   in   CH_NUM*DATA_W  channel c at [c*DATA_W +: DATA_W]; 1-cycle RAM latency
//   cfg_shift     in   4              right shift applied to samples (gain); sampled every cycle
//   cfg_connect   in   1              0 = dot mode, 1 = connected-line mode
//   freeze_req    in   1              level request to hold the displayed frame
//   frame_frozen  out  1              high for whole frames while frozen; writer must not write RAM
//   vga_wave      out  CH_NUM         per-channel trace hit, aligned 3 clk after pixel_xpos/ypos
//   vga_grid      out  1              grid pixel (GRID_OVERLAY_EN only, else tied 0)
// BEHAVIOUR
//   - Reset: ram_rd_en=0, ram_rd_addr=0, vga_wave=0, vga_grid=0, frame_frozen=0, all pipe regs 0.
//   - in_x = X_START <= xpos < X_START+2**ADDR_W; in_y = Y_TOP <= ypos <= Y_BASE.
//   - Stage 0 (clk 1): ram_rd_en <= in_x; ram_rd_addr <= xpos-X_START (ADDR_W bits) when in_x,
//     else hold; delay ypos, in_x, in_y, first_col (xpos==X_START).
//   - Stage 1 (clk 2): per channel s = data >> cfg_shift; y_c = Y_BASE - s, saturated to Y_TOP when
//     s > Y_BASE-Y_TOP. Arithmetic in 11-bit unsigned, no wrap. prev_y_c <= y_c every cycle.
//   - Stage 2 (clk 3): dot mode: hit = (ypos_d == y_c). Connect mode: hit = ypos_d within
//     [min(prev_y_c,y_c), max(prev_y_c,y_c)] inclusive; at first_col prev is replaced by y_c.
//     vga_wave[c] <= hit & in_x_d & in_y_d. Outside window vga_wave = 0.
//   - Total latency pixel position -> vga_wave = 3 clk, constant, independent of mode.
//   - cfg_shift/cfg_connect changes take effect on the next column; no glitch beyond that pixel.
//   - Freeze: frame start = (xpos==0 && ypos==0). At frame start frame_frozen <= freeze_req;
//     held for the rest of the frame. freeze_req toggling mid-frame has no effect until next
//     frame start. Rendering is identical frozen or not (read side never stalls).
//   - Columns where pixel_xpos jumps (blanking) only affect the next first_col; no other state.
//   - Async reset mid-frame clears pipeline; first valid vga_wave 3 clk after rst_n release.
// CONFIGURATION
//   GRID_OVERLAY_EN defined: vga_grid (same 3-clk alignment) = 1 when in window and
//     ((xpos-X_START)%64==0 || (Y_BASE-ypos)%32==0 || ypos==Y_TOP || ypos==Y_BASE).
//   GRID_OVERLAY_EN undefined: vga_grid tied 0, no grid logic.
// TESTING
//   1 Reset: hold rst_n=0 with scan running -> all outputs 0; release -> first vga_wave at +3 clk.
//   2 Dot mode, CH0 constant 0x800, cfg_shift=4 -> s=128, vga_wave[0]=1 only on row 240,
//     every window column; CH1 constant 0 -> hit only on row 368.
//   3 Saturation: CH0=0xFFF, cfg_shift=0 -> hit only on row Y_TOP=112.
//   4 Connect mode, CH0 steps from s=10 (col 99) to s=50 (col 100), shift 0 -> col 100 hits
//     rows 318..358 inclusive; col 99 single row 358 (first_col case at col 0 single row).
//   5 Freeze: raise freeze_req mid-frame -> frame_frozen rises at next (0,0) only; drop it
//     mid-frame -> falls at following (0,0).
//   6 Window edge: xpos = X_START+2**ADDR_W -> ram_rd_en=0, vga_wave=0; GRID_OVERLAY_EN build:
//     col 64 row 200 -> vga_grid=1 at +3 clk.

Source files
------------

// File: rtl/wave_render_mc.sv
// Multi-channel waveform renderer: reads CH_NUM channels from a shared-address capture RAM in step
// with the VGA scan and flags per-channel trace hits 3 clk later. Optional grid: GRID_OVERLAY_EN.
`timescale 1ns/1ps
module wave_render_mc #(
    parameter int CH_NUM  = 2,
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int X_START = 0,
    parameter int Y_TOP   = 112,
    parameter int Y_BASE  = 368
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [9:0]               pixel_xpos,
    input  logic [9:0]               pixel_ypos,
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        ram_rd_addr,
    input  logic [CH_NUM*DATA_W-1:0] ram_rd_data,
    input  logic [3:0]               cfg_shift,
    input  logic                     cfg_connect,
    input  logic                     freeze_req,
    output logic                     frame_frozen,
    output logic [CH_NUM-1:0]        vga_wave,
    output logic                     vga_grid
);

    localparam logic [31:0]       X_LO      = X_START;
    localparam logic [31:0]       X_HI      = X_START + (1 << ADDR_W);
    localparam logic [31:0]       Y_TP      = Y_TOP;
    localparam logic [31:0]       Y_BS      = Y_BASE;
    localparam logic [10:0]       Y_TOP_11  = 11'(Y_TOP);
    localparam logic [10:0]       Y_BASE_11 = 11'(Y_BASE);
    localparam logic [DATA_W-1:0] Y_SPAN_D  = DATA_W'(Y_BASE - Y_TOP);

    logic       in_x, in_y, first_col, frame_start;
    logic [9:0] x_off;

    assign in_x        = ({22'd0, pixel_xpos} >= X_LO) && ({22'd0, pixel_xpos} < X_HI);
    assign in_y        = ({22'd0, pixel_ypos} >= Y_TP) && ({22'd0, pixel_ypos} <= Y_BS);
    assign x_off       = pixel_xpos - X_LO[9:0];
    assign first_col   = (pixel_xpos == X_LO[9:0]);
    assign frame_start = (pixel_xpos == 10'd0) && (pixel_ypos == 10'd0);

    logic [9:0] ypos_d1_reg, ypos_d2_reg;
    logic       in_x_d1_reg, in_x_d2_reg;
    logic       in_y_d1_reg, in_y_d2_reg;
    logic       first_d1_reg, first_d2_reg;

    logic [CH_NUM-1:0][10:0] y_c;
    logic [CH_NUM-1:0][10:0] prev_y_reg;
    logic [CH_NUM-1:0]       wave_next;
    logic [10:0]             ypos_11;

    assign ypos_11 = {1'b0, ypos_d2_reg};

    // RAM data arrives one cycle after the address register, so stage 1 is combinational on
    // ram_rd_data and stage 2 registers the hit: three clocks from pixel to vga_wave.
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [DATA_W-1:0] samp;
            logic [10:0]       prev_eff, lo, hi;
            logic              hit;

            assign samp     = ram_rd_data[gi*DATA_W +: DATA_W] >> cfg_shift;
            assign y_c[gi]  = (samp > Y_SPAN_D) ? Y_TOP_11 : (Y_BASE_11 - 11'(samp));
            assign prev_eff = first_d2_reg ? y_c[gi] : prev_y_reg[gi];
            assign lo       = (prev_eff < y_c[gi]) ? prev_eff : y_c[gi];
            assign hi       = (prev_eff < y_c[gi]) ? y_c[gi] : prev_eff;
            assign hit      = cfg_connect ? ((ypos_11 >= lo) && (ypos_11 <= hi))
                                          : (ypos_11 == y_c[gi]);
            assign wave_next[gi] = hit & in_x_d2_reg & in_y_d2_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_en    <= 1'b0;
            ram_rd_addr  <= '0;
            ypos_d1_reg  <= '0;
            ypos_d2_reg  <= '0;
            in_x_d1_reg  <= 1'b0;
            in_x_d2_reg  <= 1'b0;
            in_y_d1_reg  <= 1'b0;
            in_y_d2_reg  <= 1'b0;
            first_d1_reg <= 1'b0;
            first_d2_reg <= 1'b0;
            prev_y_reg   <= '0;
            vga_wave     <= '0;
            frame_frozen <= 1'b0;
        end else begin
            ram_rd_en <= in_x;
            if (in_x) begin
                ram_rd_addr <= x_off[ADDR_W-1:0];
            end
            ypos_d1_reg  <= pixel_ypos;
            ypos_d2_reg  <= ypos_d1_reg;
            in_x_d1_reg  <= in_x;
            in_x_d2_reg  <= in_x_d1_reg;
            in_y_d1_reg  <= in_y;
            in_y_d2_reg  <= in_y_d1_reg;
            first_d1_reg <= first_col;
            first_d2_reg <= first_d1_reg;
            prev_y_reg   <= y_c;
            vga_wave     <= wave_next;
            // Freeze state changes only on frame boundaries so the writer sees whole frames.
            if (frame_start) begin
                frame_frozen <= freeze_req;
            end
        end
    end

`ifdef GRID_OVERLAY_EN
    logic       grid_now, grid_d1_reg, grid_d2_reg;
    logic [4:0] y_rel;

    assign y_rel    = Y_BS[4:0] - pixel_ypos[4:0];
    assign grid_now = in_x && in_y && ((x_off[5:0] == 6'd0) || (y_rel == 5'd0) ||
                      (pixel_ypos == Y_TP[9:0]) || (pixel_ypos == Y_BS[9:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid_d1_reg <= 1'b0;
            grid_d2_reg <= 1'b0;
            vga_grid    <= 1'b0;
        end else begin
            grid_d1_reg <= grid_now;
            grid_d2_reg <= grid_d1_reg;
            vga_grid    <= grid_d2_reg;
        end
    end
`else
    assign vga_grid = 1'b0;
`endif

endmodule

// File: tb/tb_wave_render_mc.sv
// Directed self-checking bench for wave_render_mc (window narrowed to 512 columns so the right
// window edge is reachable with a 10-bit scan column).
`timescale 1ns/1ps
module tb_wave_render_mc;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [9:0]        pixel_xpos = '0;
    logic [9:0]        pixel_ypos = 10'd5;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [23:0]       ram_rd_data = '0;
    logic [3:0]        cfg_shift = '0;
    logic              cfg_connect = 1'b0;
    logic              freeze_req = 1'b0;
    logic              frame_frozen;
    logic [1:0]        vga_wave;
    logic              vga_grid;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] mem0 [512];
    logic [11:0] mem1 [512];
    logic [1:0]  seg_wave [16];
    logic        seg_grid [16];

    wave_render_mc #(
        .CH_NUM(2), .DATA_W(12), .ADDR_W(ADDR_W), .X_START(0), .Y_TOP(112), .Y_BASE(368)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .cfg_shift(cfg_shift), .cfg_connect(cfg_connect), .freeze_req(freeze_req),
        .frame_frozen(frame_frozen), .vga_wave(vga_wave), .vga_grid(vga_grid)
    );

    always #5 clk = ~clk;

    // Capture RAM with one clock of read latency.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= {mem1[ram_rd_addr], mem0[ram_rd_addr]};
    end

    task automatic fill(input logic [11:0] v0, input logic [11:0] v1);
        for (int i = 0; i < 512; i++) begin
            mem0[i] = v0;
            mem1[i] = v1;
        end
    endtask

    // Drive n consecutive columns of row y from x0, then park off-window; capture each pixel's
    // outputs three clocks after it was presented.
    task automatic scan_seg(input int y, input int x0, input int n);
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                seg_wave[i-3] = vga_wave;
                seg_grid[i-3] = vga_grid;
            end
            if (i < n) begin
                pixel_xpos = 10'(x0 + i);
                pixel_ypos = 10'(y);
            end else begin
                pixel_xpos = 10'd600;
                pixel_ypos = 10'd5;
            end
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        fill(12'h800, 12'h000);
        cfg_shift  = 4'd4;
        freeze_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            obs = {ram_rd_en, 9'(ram_rd_addr), vga_wave, vga_grid, frame_frozen, 1'b0};
            n_cmp++;
            if (obs !== 15'd0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc%0d: got %b expected 0", i, obs);
            end
            pixel_xpos = (i == 1) ? 10'd0 : 10'd10;
            pixel_ypos = (i == 1) ? 10'd0 : 10'd240;
        end
        @(negedge clk);
        rst_n = 1'b1;
        freeze_req = 1'b0;
        pixel_xpos = 10'd10;
        pixel_ypos = 10'd240;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (vga_wave !== ((k == 3) ? 2'b01 : 2'b00)) begin
                n_bad++;
                $display("FAIL reset_release +%0d: got %b expected %b", k, vga_wave,
                         (k == 3) ? 2'b01 : 2'b00);
            end
            pixel_xpos = 10'(10 + k);
        end
    endtask

    task automatic test_dot();
        int rows [5] = '{239, 240, 241, 367, 368};
        int xs [2] = '{0, 509};
        logic [1:0] exp;
        fill(12'h800, 12'h000);
        cfg_shift = 4'd4;
        cfg_connect = 1'b0;
        foreach (rows[r]) begin
            foreach (xs[s]) begin
                scan_seg(rows[r], xs[s], 3);
                exp = {rows[r] == 368, rows[r] == 240};
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (seg_wave[i] !== exp) begin
                        n_bad++;
                        $display("FAIL dot row%0d col%0d: got %b expected %b",
                                 rows[r], xs[s] + i, seg_wave[i], exp);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        int rows [2] = '{112, 113};
        logic [1:0] exp;
        fill(12'hFFF, 12'h000);
        for (int sh = 0; sh < 2; sh++) begin
            cfg_shift = (sh == 0) ? 4'd0 : 4'd4;
            foreach (rows[r]) begin
                scan_seg(rows[r], 200, 2);
                // shift 0 saturates to row 112; shift 4 gives 255 -> row 113
                exp = {1'b0, rows[r] == ((sh == 0) ? 112 : 113)};
                for (int i = 0; i < 2; i++) begin
                    n_cmp++;
                    if (seg_wave[i] !== exp) begin
                        n_bad++;
                        $display("FAIL sat shift%0d row%0d: got %b expected %b",
                                 cfg_shift, rows[r], seg_wave[i], exp);
                    end
                end
            end
        end
    endtask

    task automatic test_connect();
        int rows [5] = '{317, 318, 340, 358, 359};
        int rows0 [3] = '{318, 340, 358};
        logic [1:0] exp;
        fill(12'd10, 12'h000);
        mem0[100] = 12'd50;
        mem0[101] = 12'd50;
        mem0[1]   = 12'd50;
        cfg_shift = 4'd0;
        cfg_connect = 1'b1;
        foreach (rows[r]) begin
            scan_seg(rows[r], 96, 6);
            for (int i = 1; i < 6; i++) begin
                if (96 + i == 100)      exp = {1'b0, rows[r] >= 318 && rows[r] <= 358};
                else if (96 + i == 101) exp = {1'b0, rows[r] == 318};
                else                    exp = {1'b0, rows[r] == 358};
                n_cmp++;
                if (seg_wave[i] !== exp) begin
                    n_bad++;
                    $display("FAIL connect row%0d col%0d: got %b expected %b",
                             rows[r], 96 + i, seg_wave[i], exp);
                end
            end
        end
        foreach (rows0[r]) begin
            scan_seg(rows0[r], 0, 2);
            exp = {1'b0, rows0[r] == 358};
            n_cmp++;
            if (seg_wave[0] !== exp) begin
                n_bad++;
                $display("FAIL connect_first row%0d col0: got %b expected %b",
                         rows0[r], seg_wave[0], exp);
            end
            n_cmp++;
            if (seg_wave[1] !== 2'b01) begin
                n_bad++;
                $display("FAIL connect_first row%0d col1: got %b expected 01",
                         rows0[r], seg_wave[1]);
            end
        end
        cfg_connect = 1'b0;
    endtask

    task automatic test_freeze();
        // {xpos, ypos, freeze_req, expected frame_frozen one clock later}
        int vec [10][4] = '{
            '{100, 50, 1, 0}, '{101, 50, 0, 0}, '{0, 0, 0, 0}, '{200, 60, 1, 0},
            '{201, 60, 1, 0}, '{0, 0, 1, 1},    '{1, 0, 0, 1}, '{300, 200, 0, 1},
            '{0, 0, 0, 0},    '{1, 0, 1, 0}
        };
        foreach (vec[v]) begin
            @(negedge clk);
            pixel_xpos = 10'(vec[v][0]);
            pixel_ypos = 10'(vec[v][1]);
            freeze_req = vec[v][2][0];
            @(negedge clk);
            n_cmp++;
            if (frame_frozen !== vec[v][3][0]) begin
                n_bad++;
                $display("FAIL freeze step%0d: got %b expected %b", v, frame_frozen,
                         vec[v][3][0]);
            end
        end
        freeze_req = 1'b0;
    endtask

    task automatic test_window_edge();
        logic exp_grid;
        fill(12'h800, 12'h000);
        cfg_shift = 4'd4;
        @(negedge clk);
        pixel_xpos = 10'd511;
        pixel_ypos = 10'd240;
        @(negedge clk);
        n_cmp++;
        if (ram_rd_en !== 1'b1 || ram_rd_addr !== 9'd511) begin
            n_bad++;
            $display("FAIL edge_in_read: got en=%b addr=%0d expected en=1 addr=511",
                     ram_rd_en, ram_rd_addr);
        end
        pixel_xpos = 10'd512;
        @(negedge clk);
        n_cmp++;
        if (ram_rd_en !== 1'b0 || ram_rd_addr !== 9'd511) begin
            n_bad++;
            $display("FAIL edge_out_read: got en=%b addr=%0d expected en=0 addr=511",
                     ram_rd_en, ram_rd_addr);
        end
        pixel_xpos = 10'd600;
        pixel_ypos = 10'd5;
        @(negedge clk);
        n_cmp++;
        if (vga_wave !== 2'b01) begin
            n_bad++;
            $display("FAIL edge_col511_wave: got %b expected 01", vga_wave);
        end
        @(negedge clk);
        n_cmp++;
        if (vga_wave !== 2'b00) begin
            n_bad++;
            $display("FAIL edge_col512_wave: got %b expected 00", vga_wave);
        end
`ifdef GRID_OVERLAY_EN
        exp_grid = 1'b1;
`else
        exp_grid = 1'b0;
`endif
        scan_seg(200, 64, 2);
        n_cmp++;
        if (seg_grid[0] !== exp_grid) begin
            n_bad++;
            $display("FAIL grid_col64_row200: got %b expected %b", seg_grid[0], exp_grid);
        end
        n_cmp++;
        if (seg_grid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL grid_col65_row200: got %b expected 0", seg_grid[1]);
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_saturation();
        test_connect();
        test_freeze();
        test_window_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
